// File: rtl/stream_border_masker.sv
// Border masker for the blur-stage video stream: regains frame sync, tracks x/y, masks the kernel border, flags framing errors.
// Optional BORDER_MASKER_FRAME_STATS_EN adds frame_count / last_frame_pixels counters (tied to 0 otherwise).
module stream_border_masker #(
    parameter int          IMG_W        = 320,
    parameter int          IMG_H        = 240,
    parameter int          BORDER       = 2,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mask_en,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        startofpacket_in,
    input  logic        endofpacket_in,
    input  logic [11:0] data_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        startofpacket_out,
    output logic        endofpacket_out,
    output logic [11:0] data_out,
    input  logic        err_clear,
    output logic        err_early_sop,
    output logic        err_bad_eop,
    output logic        err_orphan,
    output logic [15:0] frame_count,
    output logic [18:0] last_frame_pixels
);
    localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);
    localparam logic [8:0] X_LO   = 9'(BORDER);
    localparam logic [7:0] Y_LO   = 8'(BORDER);
    localparam logic [8:0] X_HI   = 9'(IMG_W - BORDER);
    localparam logic [7:0] Y_HI   = 8'(IMG_H - BORDER);

    typedef enum logic {HUNT = 1'b0, ACTIVE = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [8:0]  x_reg, x_next, cur_x;
    logic [7:0]  y_reg, y_next, cur_y;
    logic        in_beat, restart, accept_pix, at_last, in_border;
    logic        fwd_valid;
    logic [13:0] fwd_word;
    logic        ev_orphan, ev_early_sop, ev_bad_eop;
    logic        err_orphan_reg, err_early_sop_reg, err_bad_eop_reg;

    // Output register plus skid register, each word = {sop, eop, data}
    logic        ready_out_reg;
    logic        out_valid_reg, out_valid_next, skid_valid_reg, skid_valid_next;
    logic [13:0] out_word_reg, out_word_next, skid_word_reg, skid_word_next;
    logic        pop;

    assign in_beat    = valid_in & ready_out_reg;
    assign restart    = in_beat & startofpacket_in;
    assign accept_pix = in_beat & (startofpacket_in | (state_reg == ACTIVE));
    // A sop beat always sits at 0,0 regardless of where the old frame was
    assign cur_x      = restart ? 9'd0 : x_reg;
    assign cur_y      = restart ? 8'd0 : y_reg;
    assign at_last    = (cur_x == X_LAST) && (cur_y == Y_LAST);
    assign in_border  = (cur_x < X_LO) || (cur_x >= X_HI) || (cur_y < Y_LO) || (cur_y >= Y_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        if (accept_pix) begin
            if (at_last || endofpacket_in) begin
                state_next = HUNT;
                x_next     = '0;
                y_next     = '0;
            end else begin
                state_next = ACTIVE;
                if (cur_x == X_LAST) begin
                    x_next = '0;
                    y_next = cur_y + 8'd1;
                end else begin
                    x_next = cur_x + 9'd1;
                    y_next = cur_y;
                end
            end
        end
    end

    always_comb begin
        fwd_valid    = accept_pix;
        fwd_word     = {startofpacket_in, endofpacket_in | at_last,
                        (mask_en && in_border) ? BORDER_COLOR : data_in};
        ev_orphan    = in_beat && (state_reg == HUNT) && !startofpacket_in;
        ev_early_sop = restart && (state_reg == ACTIVE) && ((x_reg != 9'd0) || (y_reg != 8'd0));
        ev_bad_eop   = accept_pix && (at_last != endofpacket_in);
    end

    // Errors stay set when a clear coincides with a fresh event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan_reg    <= 1'b0;
            err_early_sop_reg <= 1'b0;
            err_bad_eop_reg   <= 1'b0;
        end else begin
            err_orphan_reg    <= (err_orphan_reg    & ~err_clear) | ev_orphan;
            err_early_sop_reg <= (err_early_sop_reg & ~err_clear) | ev_early_sop;
            err_bad_eop_reg   <= (err_bad_eop_reg   & ~err_clear) | ev_bad_eop;
        end
    end

    assign pop = out_valid_reg & ready_in;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_word_next   = out_word_reg;
        skid_valid_next = skid_valid_reg;
        skid_word_next  = skid_word_reg;
        if (!out_valid_reg || pop) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_word_next   = skid_word_reg;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next = fwd_valid;
                if (fwd_valid)
                    out_word_next = fwd_word;
            end
        end else if (fwd_valid) begin
            skid_valid_next = 1'b1;
            skid_word_next  = fwd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_out_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_word_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_word_reg  <= '0;
        end else begin
            ready_out_reg  <= ~skid_valid_next;
            out_valid_reg  <= out_valid_next;
            out_word_reg   <= out_word_next;
            skid_valid_reg <= skid_valid_next;
            skid_word_reg  <= skid_word_next;
        end
    end

    assign ready_out         = ready_out_reg;
    assign valid_out         = out_valid_reg;
    assign startofpacket_out = out_word_reg[13];
    assign endofpacket_out   = out_word_reg[12];
    assign data_out          = out_word_reg[11:0];
    assign err_orphan        = err_orphan_reg;
    assign err_early_sop     = err_early_sop_reg;
    assign err_bad_eop       = err_bad_eop_reg;

`ifdef BORDER_MASKER_FRAME_STATS_EN
    logic [18:0] pix_cnt_reg, pix_base, pix_inc, last_pix_reg;
    logic [15:0] frame_count_reg;

    assign pix_base = restart ? 19'd0 : pix_cnt_reg;
    assign pix_inc  = (&pix_base) ? pix_base : pix_base + 19'd1;

    // A sop+eop beat ends two frames at once; the one-pixel frame is the latest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_reg     <= '0;
            last_pix_reg    <= '0;
            frame_count_reg <= '0;
        end else begin
            if (accept_pix)
                pix_cnt_reg <= pix_inc;
            if (accept_pix && at_last && endofpacket_in)
                frame_count_reg <= frame_count_reg + 16'd1;
            if (accept_pix && (at_last || endofpacket_in))
                last_pix_reg <= pix_inc;
            else if (ev_early_sop)
                last_pix_reg <= pix_cnt_reg;
        end
    end

    assign frame_count       = frame_count_reg;
    assign last_frame_pixels = last_pix_reg;
`else
    assign frame_count       = '0;
    assign last_frame_pixels = '0;
`endif

endmodule

// File: tb/tb_stream_border_masker.sv
// Directed bench for stream_border_masker on a reduced 20x12 image; outputs are checked against a scoreboard queue.
module tb_stream_border_masker;
    localparam int W = 20;
    localparam int H = 12;
    localparam int B = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mask_en = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        startofpacket_in = 1'b0;
    logic        endofpacket_in = 1'b0;
    logic [11:0] data_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic        startofpacket_out;
    logic        endofpacket_out;
    logic [11:0] data_out;
    logic        err_clear = 1'b0;
    logic        err_early_sop, err_bad_eop, err_orphan;
    logic [15:0] frame_count;
    logic [18:0] last_frame_pixels;

    stream_border_masker #(.IMG_W(W), .IMG_H(H), .BORDER(B), .BORDER_COLOR(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .mask_en(mask_en),
        .valid_in(valid_in), .ready_out(ready_out),
        .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in), .data_in(data_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out), .data_out(data_out),
        .err_clear(err_clear), .err_early_sop(err_early_sop), .err_bad_eop(err_bad_eop),
        .err_orphan(err_orphan), .frame_count(frame_count), .last_frame_pixels(last_frame_pixels)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [13:0] exp_q[$];
    bit          m_in_frame = 1'b0;
    int          m_idx = 0;
    int          m_frames = 0;
    int          out_pos = 0;
    int          out_total = 0;
    logic [11:0] out_log[0:N-1];
    bit          chk_ready = 1'b0;
    bit          stall_mode = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dat(int i, int seed);
        return 12'(i * 37 + seed * 11 + 5);
    endfunction

    function automatic bit is_border(int idx);
        int x = idx % W;
        int y = idx / W;
        return (x < B) || (x >= W - B) || (y < B) || (y >= H - B);
    endfunction

    function automatic int stat(int v);
`ifdef BORDER_MASKER_FRAME_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        ready_in = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor and reference model, evaluated mid-cycle
    always @(negedge clk) begin
        logic [13:0] e;
        bit          last;
        if (rst_n) begin
            if (chk_ready)
                check("ready_out_vs_fill", 32'(ready_out), 32'(exp_q.size() < 2));
            if (valid_out && ready_in) begin
                out_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'({startofpacket_out, endofpacket_out, data_out}), 32'(e));
                end
                if (startofpacket_out) out_pos = 0;
                if (out_pos < N) out_log[out_pos] = data_out;
                out_pos++;
            end
            if (valid_in && ready_out) begin
                if (startofpacket_in) begin
                    m_in_frame = 1'b1;
                    m_idx = 0;
                end
                if (m_in_frame) begin
                    last = (m_idx == N - 1);
                    e = {startofpacket_in, endofpacket_in | last,
                         (mask_en && is_border(m_idx)) ? 12'h000 : data_in};
                    exp_q.push_back(e);
                    if (last || endofpacket_in) begin
                        m_in_frame = 1'b0;
                        if (last && endofpacket_in) m_frames++;
                    end
                    m_idx++;
                end
            end
        end
    end

    task automatic send(bit sop, bit eop, logic [11:0] d);
        valid_in = 1'b1;
        startofpacket_in = sop;
        endofpacket_in = eop;
        data_in = d;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (ready_out) break;
            if (i > 1000) begin
                check("send_timeout", 32'(ready_out), 32'd1);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "FAIL send_timeout: ready_out stuck low");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        valid_in = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) idle(1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_frame(int first, int npix, bit last_eop, int seed);
        for (int i = first; i < npix; i++)
            send(i == 0, last_eop && (i == N - 1), dat(i, seed));
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        int base;
        int c0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_sop_eop_data", 32'({startofpacket_out, endofpacket_out, data_out}), 32'd0);
        check("rst_errs", 32'({err_orphan, err_early_sop, err_bad_eop}), 32'd0);
        check("rst_stats", 32'({frame_count, last_frame_pixels}), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check("ready_after_reset", 32'(ready_out), 32'd1);
        chk_ready = 1'b1;

        // Masked frame, unstalled: latency and throughput
        mask_en = 1'b1;
        base = out_total;
        c0 = cyc;
        send(1'b1, 1'b0, dat(0, 1));
        check("latency_valid", 32'(valid_out), 32'd1);
        check("latency_sop", 32'(startofpacket_out), 32'd1);
        send_frame(1, N, 1'b1, 1);
        check("throughput_cycles", 32'(cyc - c0), 32'(N));
        drain();
        check("t1_beats", 32'(out_total - base), 32'(N));
        check("t1_px_0_0", 32'(out_log[0]), 32'h000);
        check("t1_px_1_5", 32'(out_log[5*W+1]), 32'h000);
        check("t1_px_19_6", 32'(out_log[6*W+19]), 32'h000);
        check("t1_px_10_10", 32'(out_log[10*W+10]), 32'h000);
        check("t1_px_2_2", 32'(out_log[2*W+2]), 32'(dat(2*W+2, 1)));
        check("t1_px_17_9", 32'(out_log[9*W+17]), 32'(dat(9*W+17, 1)));
        check("t1_errs", 32'({err_orphan, err_early_sop, err_bad_eop}), 32'd0);
        check("t1_frame_count", 32'(frame_count), 32'(stat(1)));
        check("t1_last_pixels", 32'(last_frame_pixels), 32'(stat(N)));

        // Pass-through frame
        mask_en = 1'b0;
        send_frame(0, N, 1'b1, 2);
        drain();
        check("t2_px_0", 32'(out_log[0]), 32'(dat(0, 2)));
        check("t2_px_last", 32'(out_log[N-1]), 32'(dat(N-1, 2)));

        // Random backpressure
        mask_en = 1'b1;
        stall_mode = 1'b1;
        base = out_total;
        send_frame(0, N, 1'b1, 3);
        stall_mode = 1'b0;
        drain();
        check("t3_beats", 32'(out_total - base), 32'(N));
        check("t3_px_2_2", 32'(out_log[2*W+2]), 32'(dat(2*W+2, 3)));
        check("t3_px_0_0", 32'(out_log[0]), 32'h000);

        // Orphans before sync
        base = out_total;
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 12'(i + 1));
        idle(3);
        check("t4_orphans_dropped", 32'(out_total - base), 32'd0);
        check("t4_err_orphan", 32'(err_orphan), 32'd1);
        send_frame(0, N, 1'b1, 4);
        drain();
        check("t4_beats", 32'(out_total - base), 32'(N));
        pulse_clear();
        check("t4_orphan_cleared", 32'(err_orphan), 32'd0);

        // Early sop after 100 pixels
        send_frame(0, 100, 1'b1, 5);
        check("t5_no_early_yet", 32'(err_early_sop), 32'd0);
        send(1'b1, 1'b0, dat(0, 6));
        check("t5_err_early_sop", 32'(err_early_sop), 32'd1);
        check("t5_last_pixels", 32'(last_frame_pixels), 32'(stat(100)));
        send_frame(1, N, 1'b1, 6);
        drain();
        check("t5_restart_px", 32'(out_log[2*W+2]), 32'(dat(2*W+2, 6)));
        check("t5_frame_count", 32'(frame_count), 32'(stat(m_frames)));
        pulse_clear();
        check("t5_cleared", 32'({err_orphan, err_early_sop, err_bad_eop}), 32'd0);

        // Missing eop on the final pixel
        base = m_frames;
        send_frame(0, N, 1'b0, 7);
        drain();
        check("t6_err_bad_eop", 32'(err_bad_eop), 32'd1);
        check("t6_frame_count", 32'(frame_count), 32'(stat(base)));
        check("t6_last_pixels", 32'(last_frame_pixels), 32'(stat(N)));
        base = out_total;
        send(1'b0, 1'b0, 12'h123);
        idle(3);
        check("t6_hunt_orphan", 32'(err_orphan), 32'd1);
        check("t6_hunt_dropped", 32'(out_total - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_border_masker.md
Name: stream_border_masker

Overview:
- Sits directly downstream of the blur stage in the 320x240 RGB444 Avalon-ST video path.
- Regains frame sync, tracks the pixel coordinate, and replaces border pixels with a fixed colour. The border is where the blur kernel window was incomplete.
- Checks frame framing and raises sticky error flags.
- Registers the stream through a 2-entry skid buffer, so ready_out toward the blur stage is driven from a flop.

Parameters:
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- BORDER, 2, border width in pixels on all four edges (2 = 5x5 kernel radius)
- BORDER_COLOR, 12'h000, RGB444 value substituted in the border

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mask_en  in  1  1 = substitute border pixels; 0 = pass all pixels unchanged
- valid_in  in  1  upstream pixel valid
- ready_out  out  1  this block can accept a pixel
- startofpacket_in  in  1  first pixel of frame
- endofpacket_in  in  1  last pixel of frame
- data_in  in  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}
- valid_out  out  1  output pixel valid
- ready_in  in  1  downstream can accept
- startofpacket_out  out  1  first pixel of frame
- endofpacket_out  out  1  last pixel of frame
- data_out  out  12  pixel out
- err_clear  in  1  synchronous clear of the sticky error flags
- err_early_sop  out  1  sticky: sop arrived before the frame completed
- err_bad_eop  out  1  sticky: eop at the wrong position, or missing at pixel IMG_W*IMG_H-1
- err_orphan  out  1  sticky: pixel received while unsynchronised
- frame_count  out  16  completed frames (FRAME_STATS_EN only)
- last_frame_pixels  out  19  pixel count of the last terminated frame (FRAME_STATS_EN only)

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 except ready_out, which is 1 once rst_n deasserts (skid buffer empty).
  - State is HUNT; x=0, y=0.
- Handshakes:
  - Input beat = valid_in & ready_out.
  - Output beat = valid_out & ready_in.
  - ready_out = ~skid_full (registered).
  - valid_out and the src data/sop/eop are held stable while ready_in=0.
- Latency: 1 cycle from input beat to valid_out when unstalled. Full throughput of 1 pixel/cycle with ready_in=1.
- Skid buffer:
  - Two entries: output register plus skid register.
  - On a stall, the output register holds and the next beat goes to the skid register.
  - ready_out drops the cycle after the skid fills.
  - No beat is ever lost or duplicated.
- State machine:
  - HUNT:
    - Beats without sop are consumed, not forwarded, and set err_orphan.
    - A beat with sop is forwarded with x=0, y=0, and the state goes to ACTIVE.
  - ACTIVE:
    - Each beat advances x. At x=IMG_W-1, x wraps to 0 and y increments.
    - A beat with sop at (x,y)≠(0,0) sets err_early_sop, terminates the previous frame and restarts the coordinate at 0,0. That beat is forwarded with sop=1.
    - A beat at x=IMG_W-1, y=IMG_H-1:
      - If it has eop: frame_count+1, and the state goes to HUNT.
      - If it lacks eop: err_bad_eop is set, the pixel is forwarded with eop forced to 1, and the state goes to HUNT.
    - eop at any other position sets err_bad_eop. It is forwarded as-is, and the state goes to HUNT.
    - Simultaneous sop and eop on one beat: sop handling applies first, then the eop check, at coordinate 0,0.
- Masking:
  - A pixel is in the border when x<BORDER, or x>=IMG_W-BORDER, or y<BORDER, or y>=IMG_H-BORDER.
  - When mask_en=1, border pixels output BORDER_COLOR.
  - sop/eop always pass (subject to the forced-eop rule above).
  - mask_en is sampled per input beat; a change mid-frame takes effect on the next accepted pixel.
- Errors:
  - Flags are sticky until err_clear=1.
  - If err_clear coincides with a new error event, the flag stays set.
- Widths: x is 9 bits, y is 8 bits. The pixel counter is 19 bits and saturates at all-ones.
- Reset mid-frame: the skid buffer is flushed, valid_out=0, and the state is HUNT. The next frame needs a fresh sop.

Optional Feature:
- Macro: BORDER_MASKER_FRAME_STATS_EN
- Defined:
  - frame_count increments on each correctly terminated frame and wraps at 2^16.
  - last_frame_pixels latches the pixel count whenever a frame terminates (correct eop, bad eop, or early sop).
- Undefined: both ports remain present, tied to 0, and no counter logic is synthesised.

Test Plan:
- Reset, then a full 320x240 frame with ready_in=1 and mask_en=1 → 76800 output beats, 1-cycle latency. Pixels (0,0),(1,5),(319,100),(100,238) = 12'h000; (2,2),(317,237) = input value. sop on beat 0, eop on beat 76799, no errors.
- Same frame with mask_en=0 → output equals input bit-exactly.
- ready_in toggled 1-0-0-1 pseudo-randomly (50%) over a frame → ready_out falls within 1 cycle of the skid filling. Output sequence is identical to the unstalled run, with no drop or duplicate.
- 10 pixels without sop after reset, then a valid frame → first 10 dropped, err_orphan=1, frame forwarded intact. err_clear pulse → err_orphan=0.
- sop at pixel 1000 of a frame → err_early_sop=1, coordinate restarts at 0,0. With FRAME_STATS_EN, last_frame_pixels=1000.
- Frame whose eop is missing at pixel 76799 → output eop forced at beat 76799, err_bad_eop=1, state HUNT. With FRAME_STATS_EN, frame_count unchanged.
